vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Arbitrates a single-port synchronous frame-buffer RAM between the VGA display path and a pixel writer (drawing engine). It consumes the free-running horizontal and vertical timing counters (H_counter 0..3199 at four clocks per pixel, V_counter 0..520), fetches one low-resolution frame-buffer word per visible pixel, and hands every remaining RAM slot to the writer through a req/ack handshake. It sits between the timing counters, the frame RAM and the RGB output stage.

## Interface
- FB_W, 128, frame-buffer width in words
- FB_H, 96, frame-buffer height in words
- SCALE, 5, screen pixels per frame-buffer word, both axes (640/FB_W = 480/FB_H)
- ADDR_W, 14, RAM address width; must satisfy 2^ADDR_W ≥ FB_W*FB_H
- DATA_W, 3, RAM word width (RGB)
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- H_counter  in  12  horizontal count, 0..3199
- V_counter  in  10  vertical count, 0..520
- wr_req  in  1  writer request; held with wr_addr/wr_data stable until wr_ack
- wr_addr  in  ADDR_W  linear write address, row*FB_W+col
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse: write issued to RAM this cycle
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0
- pixel_rgb  out  DATA_W  display pixel
- video_on  out  1  active-region flag aligned with pixel_rgb
- frame_done  out  1  one-cycle pulse at start of vertical blanking

## Operation
- Pixel index px = H_counter[11:2]. Active region: px < 640 and V_counter < 480.
- Display slot: counters show active and H_counter[1:0]==0. Slot is owned by the display; a write can never be granted in it.
- Display address = row*FB_W + col, maintained incrementally: col advances every SCALE pixels, resets at px==0; row advances every SCALE lines, resets at V_counter==0. No multipliers or dividers.
- Write grant: wr_req high, cycle is not a display slot, and no ack was issued in the previous cycle. Max write rate: one per two cycles.
- Write with wr_addr ≥ FB_W*FB_H: wr_ack still pulses, ram_en/ram_we stay 0 (write dropped).
- Neither read nor write granted: ram_en=0, ram_we=0, ram_addr/ram_wdata hold.
- pixel_rgb: 0 whenever delayed video_on is 0.
- frame_done: pulses when counters show H_counter==0, V_counter==480.
- Reset: all outputs 0, col/row counters 0, any pending request un-acked (writer must re-present it after reset).

## Timing
- All outputs registered. Decision at cycle t, and ram_en/ram_we/ram_addr/ram_wdata/wr_ack driven at t+1.
- Read: decided when H_counter[1:0]==0. RAM access when H_counter[1:0]==1. ram_rdata valid at ==2. pixel_rgb updated at ==3.
- Pixel p (line-local) is shown on pixel_rgb from H_counter 4p+3 through 4p+6. video_on is active delayed 3 cycles. Top level delays hsync/vsync by 3 cycles.
- frame_done is high for exactly one cycle, the cycle after the counters show H_counter==0, V_counter==480.
- A writer that keeps wr_req high after ack is treated as a new request, granted no earlier than 2 cycles after the previous ack.

## Configuration
- VGA_VBLANK_WRITE_ONLY_EN defined: writes granted only when V_counter ≥ 480 (tear-free). Requests during V_counter < 480 wait.
- Undefined: writes granted in every non-display slot, including active-line cycles 1–3 of each pixel and horizontal blanking.

## Test plan
- Reset held 5 cycles mid-line with wr_req=1 -> all outputs 0, no wr_ack during or in the first cycle after reset.
- FB preloaded with word k = k mod 8, counters at line V=7 -> pixel px=12 shows word 1*128+2=130 (rgb 2) during H_counter 51..54. video_on=1.
- wr_req=1, wr_addr=200, wr_data=5 presented at H_counter=0 on an active line (define undefined) -> wr_ack and ram_we at H_counter=2, ram_addr=200. No collision with read at H_counter=1.
- wr_req held continuously through blanking -> wr_ack pulses every 2nd cycle, never two consecutive.
- wr_addr=12288 -> wr_ack pulses, ram_we stays 0.
- With VGA_VBLANK_WRITE_ONLY_EN: wr_req raised at V=100 -> no ack until V=480. frame_done single pulse at H=1, V=480.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Purpose: shares one single-port frame RAM between the VGA display read path and a pixel writer (optional VGA_VBLANK_WRITE_ONLY_EN restricts writes to vertical blanking).
// Latency: decision at cycle t, RAM strobes and wr_ack at t+1, pixel_rgb/video_on three cycles after the counters.
// Backpressure: the writer holds wr_req/wr_addr/wr_data until wr_ack; at most one ack every two cycles, never in a display slot.
module vga_fb_arbiter #(
  parameter int FB_W   = 128,
  parameter int FB_H   = 96,
  parameter int SCALE  = 5,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       H_counter,
  input  logic [9:0]        V_counter,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pixel_rgb,
  output logic              video_on,
  output logic              frame_done
);

  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SW-1:0]     SUB_LAST = SW'(SCALE - 1);
  localparam logic [ADDR_W:0]   FB_SIZE  = (ADDR_W + 1)'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [SW-1:0]     ONE_S    = SW'(1);

  logic [9:0]        px;
  logic [1:0]        h_ph;
  logic              active;
  logic              disp_slot;
  logic              line_end;
  logic              wr_window;
  logic              wr_grant;
  logic              wr_in_range;
  logic [ADDR_W-1:0] disp_addr;

  // scan position of the frame-buffer word under the beam
  logic [SW-1:0]     col_sub;
  logic [ADDR_W-1:0] col;
  logic [SW-1:0]     row_sub;
  logic [ADDR_W-1:0] row_base;

  // active-region delay line feeding video_on and the pixel blanking
  logic              act_d1;
  logic              act_d2;

  assign px        = H_counter[11:2];
  assign h_ph      = H_counter[1:0];
  assign active    = (px < 10'd640) && (V_counter < 10'd480);
  assign disp_slot = active && (h_ph == 2'd0);
  assign line_end  = (H_counter == 12'd3199);
  assign disp_addr = row_base + col;
  assign wr_in_range = ({1'b0, wr_addr} < FB_SIZE);

`ifdef VGA_VBLANK_WRITE_ONLY_EN
  assign wr_window = (V_counter >= 10'd480);
`else
  assign wr_window = 1'b1;
`endif

  // the previous-cycle ack blocks back-to-back grants to a writer still holding wr_req
  assign wr_grant = wr_req && wr_window && !disp_slot && !wr_ack;

  // col advances every SCALE pixels, row base steps by FB_W every SCALE lines
  always_ff @(posedge clk) begin
    if (reset) begin
      col_sub  <= '0;
      col      <= '0;
      row_sub  <= '0;
      row_base <= '0;
    end else begin
      if (line_end) begin
        col_sub <= '0;
        col     <= '0;
        if (V_counter == 10'd520) begin
          row_sub  <= '0;
          row_base <= '0;
        end else if (row_sub == SUB_LAST) begin
          row_sub  <= '0;
          row_base <= row_base + ROW_STEP;
        end else begin
          row_sub  <= row_sub + ONE_S;
        end
      end else if (h_ph == 2'd3) begin
        if (col_sub == SUB_LAST) begin
          col_sub <= '0;
          col     <= col + ONE_A;
        end else begin
          col_sub <= col_sub + ONE_S;
        end
      end
    end
  end

  // RAM port: display read owns its slot, otherwise a granted in-range write; address/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ack    <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      wr_ack <= wr_grant;
      if (disp_slot) begin
        ram_en   <= 1'b1;
        ram_we   <= 1'b0;
        ram_addr <= disp_addr;
      end else if (wr_grant && wr_in_range) begin
        ram_en    <= 1'b1;
        ram_we    <= 1'b1;
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
      end else begin
        ram_en <= 1'b0;
        ram_we <= 1'b0;
      end
    end
  end

  // display output: capture read data in phase 2, blank outside the active region, flag start of vblank
  always_ff @(posedge clk) begin
    if (reset) begin
      act_d1     <= 1'b0;
      act_d2     <= 1'b0;
      video_on   <= 1'b0;
      pixel_rgb  <= '0;
      frame_done <= 1'b0;
    end else begin
      act_d1   <= active;
      act_d2   <= act_d1;
      video_on <= act_d2;
      if (h_ph == 2'd2) begin
        pixel_rgb <= act_d2 ? ram_rdata : '0;
      end
      frame_done <= (H_counter == 12'd0) && (V_counter == 10'd480);
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: drives the timing counters, models a 1-cycle synchronous RAM
// preloaded with word k = k mod 8, and checks reset, display reads, write grants and frame_done.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] hc;
  logic [9:0]  vc;
  logic        wr_req;
  logic [13:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_ack;
  logic        ram_en;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [2:0]  ram_wdata;
  logic [2:0]  ram_rdata;
  logic [2:0]  pixel_rgb;
  logic        video_on;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] mem [0:16383];

  vga_fb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .H_counter  (hc),
    .V_counter  (vc),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .pixel_rgb  (pixel_rgb),
    .video_on   (video_on),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // single-port synchronous RAM model
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] = ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    if (hc == 12'd3199) begin
      hc = 12'd0;
      vc = (vc == 10'd520) ? 10'd0 : vc + 10'd1;
    end else begin
      hc = hc + 12'd1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    for (int k = 0; k < 16384; k++) mem[k] = 3'(k % 8);

    // reset held 5 cycles mid-line with a pending write request
    reset = 1'b1; hc = 12'd1000; vc = 10'd3;
    wr_req = 1'b1; wr_addr = 14'd50; wr_data = 3'd1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rst_ack",   wr_ack,     0);
      chk("rst_en",    ram_en,     0);
      chk("rst_we",    ram_we,     0);
      chk("rst_addr",  ram_addr,   0);
      chk("rst_wdata", ram_wdata,  0);
      chk("rst_rgb",   pixel_rgb,  0);
      chk("rst_von",   video_on,   0);
      chk("rst_fdone", frame_done, 0);
    end
    reset = 1'b0;
    #2;
    chk("post_rst_ack", wr_ack, 0);
    wr_req = 1'b0;

    // realign: first non-reset cycle shows H=0, V=0
    reset = 1'b1;
    tick;
    hc = 12'd0; vc = 10'd0; reset = 1'b0;

    // write presented in a display slot is deferred to phase 1, acked in phase 2
    wr_req = 1'b1; wr_addr = 14'd200; wr_data = 3'd5;
    tick; // H=1
    chk("h1_en",   ram_en,   1);
    chk("h1_we",   ram_we,   0);
    chk("h1_addr", ram_addr, 0);
    chk("h1_ack",  wr_ack,   0);
    tick; // H=2
    chk("h2_ack",   wr_ack,    1);
    chk("h2_en",    ram_en,    1);
    chk("h2_we",    ram_we,    1);
    chk("h2_addr",  ram_addr,  200);
    chk("h2_wdata", ram_wdata, 5);
    chk("h2_von",   video_on,  0);
    wr_req = 1'b0;
    tick; // H=3
    chk("h3_ack", wr_ack,   0);
    chk("h3_en",  ram_en,   0);
    chk("h3_von", video_on, 1);
    chk("h3_rgb", pixel_rgb, 0);

    // line V=7: px 12 reads word 130
    n = 0;
    while (!(vc == 10'd7 && hc == 12'd49) && n < 30000) begin tick; n++; end
    chk("reach_v7", n < 30000, 1);
    chk("px12_en",   ram_en,   1);
    chk("px12_we",   ram_we,   0);
    chk("px12_addr", ram_addr, 130);
    tick; tick; // H=51
    for (int i = 0; i < 4; i++) begin
      chk("px12_rgb", pixel_rgb, 2);
      chk("px12_von", video_on,  1);
      tick;
    end
    // H=55 px13 same word; advance to H=63 where px15 shows word 131
    for (int i = 0; i < 8; i++) tick;
    chk("px15_rgb", pixel_rgb, 3);

    // continuous request in horizontal blanking: ack every second cycle
    n = 0;
    while (hc != 12'd2600 && n < 5000) begin tick; n++; end
    chk("reach_hblank", n < 5000, 1);
    wr_req = 1'b1; wr_addr = 14'd300; wr_data = 3'd6;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("burst_ack", wr_ack, (i % 2 == 0) ? 1 : 0);
      chk("burst_we",  ram_we, (i % 2 == 0) ? 1 : 0);
    end
    wr_req = 1'b0;

    // out-of-range write: acked but dropped, address/data hold
    wr_req = 1'b1; wr_addr = 14'd12288; wr_data = 3'd7;
    tick;
    chk("oor_ack",   wr_ack,    1);
    chk("oor_en",    ram_en,    0);
    chk("oor_we",    ram_we,    0);
    chk("oor_addr",  ram_addr,  300);
    chk("oor_wdata", ram_wdata, 6);
    wr_req = 1'b0;
    tick;
    chk("oor_ack_end", wr_ack, 0);

    // frame_done: single pulse the cycle after counters show H=0, V=480
    hc = 12'd3199; vc = 10'd479;
    tick; // H=0 V=480
    chk("fd_h0", frame_done, 0);
    tick; // H=1
    chk("fd_h1", frame_done, 1);
    tick; // H=2
    chk("fd_h2", frame_done, 0);
    chk("vblank_von", video_on, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
